m_imem_loader: RTL and testbench

Program loader that writes the instruction memory the CPU core fetches from. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Each word goes to the instruction memory write port at consecutive word addresses. The loader holds the core stalled until the full program is written, then releases it. It sits between the host byte link and the write side of `imem`; the core's fetch path is the read side.

---
 rtl/cpu_defs.sv | 18 +
 rtl/m_imem_loader_packer.sv | 45 ++++
 rtl/m_imem_loader.sv | 110 +++++++++++
 tb/tb_m_imem_loader.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// Shared CPU definitions: instruction-memory geometry and the program-loader
// state encoding.
package cpu_defs;

  localparam int IMEM_ADDR_W = 6;
  localparam int IMEM_DEPTH  = 64;
  localparam int LEN_W       = 16;

  typedef enum logic [2:0] {
    S_LEN0  = 3'd0,
    S_LEN1  = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } loader_state_e;

endpackage

// File: rtl/m_imem_loader_packer.sv
// Little-endian byte packer: drops each accepted byte into lane byte_idx of a
// 32-bit word and flags the byte that completes the word.
module m_byte_packer (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_clear,
  input  logic        w_byte_valid,
  input  logic [7:0]  w_byte,
  output logic [31:0] w_word,
  output logic        w_word_done
);

  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;

  // NOTE: combinational blocks use blocking '=' with defaults assigned first,
  // so every path drives every output and no latch is inferred.
  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    if (w_clear) begin
      word_d = '0;
      idx_d  = '0;
    end else if (w_byte_valid) begin
      word_d[{idx_q, 3'b000} +: 8] = w_byte;
      idx_d                        = idx_q + 2'd1;
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values of the others.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      word_q <= '0;
      idx_q  <= '0;
    end else begin
      word_q <= word_d;
      idx_q  <= idx_d;
    end
  end

  assign w_word      = word_q;
  assign w_word_done = w_byte_valid & ~w_clear & (idx_q == 2'd3);

endmodule

// File: rtl/m_imem_loader.sv
// Program loader: parses a length-prefixed byte stream, writes little-endian
// words into imem at consecutive addresses, then releases the core.
module m_imem_loader
  import cpu_defs::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DEPTH  = IMEM_DEPTH   // must equal 2**ADDR_W
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_rx_valid,
  input  logic [7:0]        w_rx_data,
  output logic              w_rx_ready,
  output logic              w_we,
  output logic [ADDR_W-1:0] w_waddr,
  output logic [31:0]       w_wdata,
  output logic              w_cpu_run,
  output logic              w_err,
  output logic [ADDR_W:0]   w_words_loaded
);

  loader_state_e    state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [ADDR_W:0]  word_idx_q, word_idx_d;

  logic             rx_xfer;
  logic             pk_clear;
  logic             pk_valid;
  logic             pk_done;
  logic [LEN_W-1:0] len_full;
  logic [LEN_W-1:0] next_count;

  assign rx_xfer    = w_rx_valid & w_rx_ready;
  assign pk_valid   = rx_xfer & (state_q == S_DATA);
  assign len_full   = {w_rx_data, len_q[7:0]};
  // One extra counter bit lets N == DEPTH finish without the index wrapping.
  assign next_count = {{(LEN_W-ADDR_W-1){1'b0}}, word_idx_q} + LEN_W'(1);

  m_byte_packer u_packer (
    .w_clk        (w_clk),
    .w_rst        (w_rst),
    .w_clear      (pk_clear),
    .w_byte_valid (pk_valid),
    .w_byte       (w_rx_data),
    .w_word       (w_wdata),
    .w_word_done  (pk_done)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    pk_clear   = 1'b0;
    unique case (state_q)
      S_LEN0: if (rx_xfer) begin
        len_d[7:0] = w_rx_data;
        state_d    = S_LEN1;
      end
      S_LEN1: if (rx_xfer) begin
        len_d = len_full;
        if (len_full == '0 || len_full > LEN_W'(DEPTH)) begin
          state_d = S_ERR;
        end else begin
          state_d    = S_DATA;
          word_idx_d = '0;
          pk_clear   = 1'b1;
        end
      end
      S_DATA: if (pk_done) state_d = S_WRITE;
      S_WRITE: begin
        word_idx_d = word_idx_q + 1'b1;
        state_d    = (next_count == len_q) ? S_DONE : S_DATA;
      end
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q    <= S_LEN0;
      len_q      <= '0;
      word_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
    end
  end

  // Handshake and status outputs depend on state alone, never on w_rx_valid.
  always_comb begin
    w_rx_ready = 1'b0;
    w_we       = 1'b0;
    w_cpu_run  = 1'b0;
    w_err      = 1'b0;
    unique case (state_q)
      S_LEN0, S_LEN1, S_DATA: w_rx_ready = 1'b1;
      S_WRITE:                w_we       = 1'b1;
      S_DONE:                 w_cpu_run  = 1'b1;
      S_ERR:                  w_err      = 1'b1;
      default:                w_err      = 1'b1;
    endcase
  end

  assign w_waddr        = word_idx_q[ADDR_W-1:0];
  assign w_words_loaded = word_idx_q;

endmodule

// File: tb/tb_m_imem_loader.sv
// Directed bench for m_imem_loader: normal loads, stalled sender, bad lengths,
// full-depth load, mid-word reset and post-done byte rejection.
module tb_m_imem_loader;

  localparam int ADDR_W = 6;

  logic              w_clk = 1'b0;
  logic              w_rst = 1'b1;
  logic              w_rx_valid = 1'b0;
  logic [7:0]        w_rx_data = 8'h00;
  logic              w_rx_ready;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [31:0]       w_wdata;
  logic              w_cpu_run;
  logic              w_err;
  logic [ADDR_W:0]   w_words_loaded;

  m_imem_loader #(.ADDR_W(ADDR_W), .DEPTH(64)) dut (
    .w_clk          (w_clk),
    .w_rst          (w_rst),
    .w_rx_valid     (w_rx_valid),
    .w_rx_data      (w_rx_data),
    .w_rx_ready     (w_rx_ready),
    .w_we           (w_we),
    .w_waddr        (w_waddr),
    .w_wdata        (w_wdata),
    .w_cpu_run      (w_cpu_run),
    .w_err          (w_err),
    .w_words_loaded (w_words_loaded)
  );

  always #5 w_clk = ~w_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Write monitor, sampled on the falling edge.
  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  int cyc = 0, last_we_cyc = -1, run_rise_cyc = -1;
  logic run_prev = 1'b0;

  always @(negedge w_clk) begin
    cyc++;
    if (w_we === 1'b1) begin
      wr_addr.push_back(w_waddr);
      wr_data.push_back(w_wdata);
      last_we_cyc = cyc;
    end
    if (w_cpu_run === 1'b1 && run_prev !== 1'b1) run_rise_cyc = cyc;
    run_prev = w_cpu_run;
  end

  task automatic do_reset();
    @(negedge w_clk);
    w_rst      = 1'b1;
    w_rx_valid = 1'b0;
    #1;
    check("rst_ready",  32'(w_rx_ready), 32'd1);
    check("rst_we",     32'(w_we), 32'd0);
    check("rst_waddr",  32'(w_waddr), 32'd0);
    check("rst_wdata",  w_wdata, 32'd0);
    check("rst_run",    32'(w_cpu_run), 32'd0);
    check("rst_err",    32'(w_err), 32'd0);
    check("rst_loaded", 32'(w_words_loaded), 32'd0);
    @(negedge w_clk);
    wr_addr.delete();
    wr_data.delete();
    last_we_cyc  = -1;
    run_rise_cyc = -1;
    w_rst = 1'b0;
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    w_rx_valid = 1'b1;
    w_rx_data  = b;
    while (w_rx_ready !== 1'b1 && n < 50) begin
      @(negedge w_clk);
      n++;
    end
    if (w_rx_ready !== 1'b1) begin
      check("rx_ready_timeout", 32'(w_rx_ready), 32'd1);
      w_rx_valid = 1'b0;
      return;
    end
    @(posedge w_clk);
    @(negedge w_clk);
    w_rx_valid = 1'b0;
    if (gap) @(negedge w_clk);
  endtask

  task automatic send_stream(input logic [7:0] s[$], input bit gap);
    foreach (s[i]) send_byte(s[i], gap);
  endtask

  task automatic wait_run();
    int n = 0;
    while (w_cpu_run !== 1'b1 && n < 40) begin
      @(negedge w_clk);
      n++;
    end
    check("run_timeout", 32'(w_cpu_run), 32'd1);
    repeat (2) @(negedge w_clk);
  endtask

  task automatic check_two_word(input string pfx);
    check({pfx, "_nwr"}, 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check({pfx, "_a0"}, 32'(wr_addr[0]), 32'd0);
      check({pfx, "_d0"}, wr_data[0], 32'h0050_0013);
      check({pfx, "_a1"}, 32'(wr_addr[1]), 32'd1);
      check({pfx, "_d1"}, wr_data[1], 32'h00A0_0093);
    end
    check({pfx, "_loaded"}, 32'(w_words_loaded), 32'd2);
    check({pfx, "_run"}, 32'(w_cpu_run), 32'd1);
    check({pfx, "_err"}, 32'(w_err), 32'd0);
    check({pfx, "_run_lat"}, 32'(run_rise_cyc), 32'(last_we_cyc + 1));
  endtask

  initial begin
    logic [7:0] s[$];
    int bad;
    int ready_hits;

    // Two-word program, back-to-back bytes.
    do_reset();
    s = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'hA0, 8'h00};
    send_stream(s, 1'b0);
    wait_run();
    check_two_word("b2b");

    // Same program with a one-cycle gap after every byte.
    do_reset();
    send_stream(s, 1'b1);
    wait_run();
    check_two_word("gap");

    // Zero-length header.
    do_reset();
    s = '{8'h00, 8'h00};
    send_stream(s, 1'b0);
    repeat (3) @(negedge w_clk);
    check("n0_err",   32'(w_err), 32'd1);
    check("n0_ready", 32'(w_rx_ready), 32'd0);
    check("n0_run",   32'(w_cpu_run), 32'd0);
    check("n0_nwr",   32'(wr_addr.size()), 32'd0);

    // Over-length header, N = 65.
    do_reset();
    s = '{8'h41, 8'h00};
    send_stream(s, 1'b0);
    repeat (3) @(negedge w_clk);
    check("n65_err",   32'(w_err), 32'd1);
    check("n65_ready", 32'(w_rx_ready), 32'd0);
    check("n65_run",   32'(w_cpu_run), 32'd0);
    check("n65_nwr",   32'(wr_addr.size()), 32'd0);

    // Full depth: 64 words, word i = i.
    do_reset();
    s = '{8'h40, 8'h00};
    for (int i = 0; i < 64; i++) begin
      s.push_back(8'(i));
      s.push_back(8'h00);
      s.push_back(8'h00);
      s.push_back(8'h00);
    end
    send_stream(s, 1'b0);
    wait_run();
    check("n64_nwr", 32'(wr_addr.size()), 32'd64);
    bad = 0;
    for (int i = 0; i < 64 && i < wr_addr.size(); i++) begin
      if (32'(wr_addr[i]) != 32'(i) || wr_data[i] != 32'(i)) bad++;
    end
    check("n64_bad_words", 32'(bad), 32'd0);
    check("n64_loaded",    32'(w_words_loaded), 32'd64);
    check("n64_run",       32'(w_cpu_run), 32'd1);
    check("n64_err",       32'(w_err), 32'd0);
    check("n64_run_lat",   32'(run_rise_cyc), 32'(last_we_cyc + 1));

    // Reset after two data bytes of a word, then a fresh one-word stream.
    do_reset();
    s = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    send_stream(s, 1'b0);
    do_reset();
    s = '{8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    send_stream(s, 1'b0);
    wait_run();
    check("rst_mid_nwr", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() == 1) begin
      check("rst_mid_a0", 32'(wr_addr[0]), 32'd0);
      check("rst_mid_d0", wr_data[0], 32'h4433_2211);
    end
    check("rst_mid_loaded", 32'(w_words_loaded), 32'd1);

    // Bytes offered after completion are refused.
    w_rx_valid = 1'b1;
    w_rx_data  = 8'hFF;
    ready_hits = 0;
    repeat (10) begin
      @(negedge w_clk);
      if (w_rx_ready !== 1'b0) ready_hits++;
    end
    w_rx_valid = 1'b0;
    check("done_ready_hits", 32'(ready_hits), 32'd0);
    check("done_nwr",        32'(wr_addr.size()), 32'd1);
    check("done_run",        32'(w_cpu_run), 32'd1);
    check("done_loaded",     32'(w_words_loaded), 32'd1);

    // Asynchronous reset drops the run signal without waiting for an edge.
    @(posedge w_clk);
    #2;
    w_rst = 1'b1;
    #1;
    check("async_run_drop", 32'(w_cpu_run), 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
